// File: rtl/a_arb_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package a_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        M1_BUS = 3'd1,
        M2_BUS = 3'd2,
        LOAN   = 3'd3,
        RETURN = 3'd4
    } arb_state_t;

    // Master indices into req/done/grant.
    localparam int M1 = 0;
    localparam int M2 = 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M1   = 2'b01;
    localparam logic [1:0] GRANT_M2   = 2'b10;

    // Bus grant presented while the arbiter sits in a given state.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            M1_BUS:         grant_of = GRANT_M1;
            M2_BUS, LOAN:   grant_of = GRANT_M2;
            default:        grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/a_stall_timer.sv
// Saturating up-counter with a strict "count exceeds LIMIT" flag.
module a_stall_timer #(
    parameter int unsigned LIMIT = 1000,
    parameter int          W     = 32
) (
    input  logic clk,
    input  logic rstN,
    input  logic clr,
    input  logic en,
    output logic over
);

    localparam logic [W-1:0] CMAX = '1;
    localparam logic [W-1:0] LIM  = W'(LIMIT);

    logic [W-1:0] count;

    // Count enabled cycles; clear wins over enable; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CMAX)) begin
            count <= count + W'(1);
        end
    end

    assign over = (count > LIM);

endmodule

// File: rtl/a_bus_arbiter.sv
// Two-master bus arbiter: M1 has fixed priority, but a long slave stall
// while M1 owns the bus lends the bus to M2 for a bounded window.
module a_bus_arbiter
    import a_arb_pkg::*;
#(
    parameter int unsigned THRESH   = 1000,
    parameter int unsigned LOAN_MAX = 64,
    parameter int          TIMER_W  = 32
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       slave_ready,
    output logic [1:0] grant,
    output logic       hold,
    output logic       loan_active
);

    // The loan counter flags count == LOAN_MAX-1; a one-cycle loan needs no counter.
    localparam int unsigned LOAN_LIMIT = (LOAN_MAX >= 2) ? (LOAN_MAX - 2) : 0;

    arb_state_t state;
    arb_state_t nxt;

    logic stall_over;
    logic loan_over;
    logic loan_end;

    // Stall time only accrues while M1 owns the bus; any ready cycle or leaving
    // M1_BUS restarts it, so every loan needs a fresh stall.
    a_stall_timer #(
        .LIMIT (THRESH),
        .W     (TIMER_W)
    ) u_stall (
        .clk  (clk),
        .rstN (rstN),
        .clr  ((state != M1_BUS) || slave_ready),
        .en   ((state == M1_BUS) && !slave_ready),
        .over (stall_over)
    );

    // Loan length counter; starts from zero on every entry to LOAN.
    a_stall_timer #(
        .LIMIT (LOAN_LIMIT),
        .W     (TIMER_W)
    ) u_loan (
        .clk  (clk),
        .rstN (rstN),
        .clr  (state != LOAN),
        .en   (state == LOAN),
        .over (loan_over)
    );

    assign loan_end = (LOAN_MAX <= 1) ? 1'b1 : loan_over;

    // Next-state arbitration; M1 release beats a pending loan, done from a non-owner is ignored.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req[M1])      nxt = M1_BUS;
                else if (req[M2]) nxt = M2_BUS;
            end
            M1_BUS: begin
                if (done[M1] || !req[M1])       nxt = IDLE;
                else if (stall_over && req[M2]) nxt = LOAN;
            end
            LOAN: begin
                if (done[M2] || !req[M2] || loan_end) nxt = RETURN;
            end
            RETURN: begin
                nxt = req[M1] ? M1_BUS : IDLE;
            end
            M2_BUS: begin
                if (done[M2] || !req[M2]) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register with outputs registered alongside it, decoded from the next state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            grant       <= GRANT_NONE;
            hold        <= 1'b0;
            loan_active <= 1'b0;
        end else begin
            state       <= nxt;
            grant       <= grant_of(nxt);
            hold        <= (nxt == LOAN) || (nxt == RETURN);
            loan_active <= (nxt == LOAN);
        end
    end

endmodule

// File: tb/tb_a_bus_arbiter.sv
// Self-checking bench for a_bus_arbiter with THRESH=4, LOAN_MAX=8.
module tb_a_bus_arbiter;

    logic       clk;
    logic       rstN;
    logic [1:0] req;
    logic [1:0] done;
    logic       slave_ready;
    logic [1:0] grant;
    logic       hold;
    logic       loan_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {grant, hold, loan_active} after the edge that samples the driven inputs.
    logic [3:0] exp_q[$];

    localparam logic [3:0] E_IDLE = 4'b00_0_0;
    localparam logic [3:0] E_M1   = 4'b01_0_0;
    localparam logic [3:0] E_M2   = 4'b10_0_0;
    localparam logic [3:0] E_LOAN = 4'b10_1_1;
    localparam logic [3:0] E_RET  = 4'b00_1_0;

    a_bus_arbiter #(
        .THRESH   (4),
        .LOAN_MAX (8),
        .TIMER_W  (32)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req),
        .done        (done),
        .slave_ready (slave_ready),
        .grant       (grant),
        .hold        (hold),
        .loan_active (loan_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
    task automatic step(input logic [1:0] r, input logic [1:0] d, input logic sr,
                        input logic [3:0] e, input string tag);
        logic [3:0] x;
        req         = r;
        done        = d;
        slave_ready = sr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        done = 2'b00;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            check(tag, {28'd0, grant, hold, loan_active}, {28'd0, x});
        end
    endtask

    // One-hot grant must hold on every cycle.
    always @(negedge clk) begin
        if (grant === 2'b11) check("grant_onehot", {30'd0, grant}, 32'd0);
    end

    initial begin
        rstN        = 1'b0;
        req         = 2'b00;
        done        = 2'b00;
        slave_ready = 1'b1;
        #12;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_hold",  {31'd0, hold}, 32'd0);
        check("rst_loan",  {31'd0, loan_active}, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Priority and plain ownership
        step(2'b11, 2'b00, 1'b1, E_M1,   "prio_m1");
        step(2'b11, 2'b10, 1'b1, E_M1,   "m2_done_ignored");
        step(2'b10, 2'b01, 1'b1, E_IDLE, "m1_done");
        step(2'b10, 2'b00, 1'b1, E_M2,   "m2_after_m1");
        step(2'b11, 2'b00, 1'b1, E_M2,   "m2_nonpreempt");
        step(2'b01, 2'b10, 1'b1, E_IDLE, "m2_done");
        step(2'b11, 2'b00, 1'b1, E_M1,   "m1_again");

        // Continuous stall: loan on the 6th stall edge
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, E_M1, "stall_wait");
        step(2'b11, 2'b00, 1'b0, E_LOAN, "loan_start");

        // Loan expiry: 8 loan cycles total, one RETURN cycle, back to M1
        for (int i = 0; i < 7; i++) step(2'b11, 2'b00, 1'b0, E_LOAN, "loan_hold");
        step(2'b11, 2'b00, 1'b1, E_RET, "loan_expire");
        step(2'b11, 2'b00, 1'b1, E_M1,  "return_m1");

        // Ready pulse at stall cycle 3 restarts the stall count
        step(2'b11, 2'b00, 1'b0, E_M1, "pulse_s1");
        step(2'b11, 2'b00, 1'b0, E_M1, "pulse_s2");
        step(2'b11, 2'b00, 1'b1, E_M1, "pulse_clear");
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, E_M1, "stall_rewait");
        step(2'b11, 2'b00, 1'b0, E_LOAN, "loan_after_clear");

        // Early return on done[1] in loan cycle 2; done[0] during loan ignored
        step(2'b11, 2'b01, 1'b1, E_LOAN, "m1_done_in_loan");
        step(2'b11, 2'b10, 1'b1, E_RET,  "early_return");
        step(2'b11, 2'b00, 1'b1, E_M1,   "early_back_m1");

        // M1 drops its request during the loan: RETURN then IDLE
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, E_M1, "stall_wait3");
        step(2'b11, 2'b00, 1'b0, E_LOAN, "loan3");
        step(2'b10, 2'b00, 1'b1, E_LOAN, "m1_drop_in_loan");
        step(2'b10, 2'b10, 1'b1, E_RET,  "ret_m1_gone");
        step(2'b00, 2'b00, 1'b1, E_IDLE, "ret_to_idle");

        // done[0] on the edge the stall exceeds the threshold wins over the loan
        step(2'b11, 2'b00, 1'b1, E_M1, "m1_t6");
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, E_M1, "stall_wait4");
        step(2'b10, 2'b01, 1'b0, E_IDLE, "done_beats_loan");

        // Asynchronous reset in the middle of a loan
        step(2'b11, 2'b00, 1'b1, E_M1, "m1_t1");
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, E_M1, "stall_wait5");
        step(2'b11, 2'b00, 1'b0, E_LOAN, "loan4");
        #2;
        rstN = 1'b0;
        #1;
        check("async_rst_grant", {30'd0, grant}, 32'd0);
        check("async_rst_hold",  {31'd0, hold}, 32'd0);
        check("async_rst_loan",  {31'd0, loan_active}, 32'd0);
        req = 2'b00;
        @(posedge clk);
        #1;
        check("rst_no_return", {28'd0, grant, hold, loan_active}, {28'd0, E_IDLE});
        rstN = 1'b1;
        step(2'b00, 2'b00, 1'b1, E_IDLE, "post_reset_idle");
        step(2'b01, 2'b00, 1'b1, E_M1,   "post_reset_m1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
